// File: rtl/zigbee_pkg.sv
// Shared constants, state encoding and line classifier for the AT response parser.
package zigbee_pkg;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  localparam logic [1:0] RESP_NONE  = 2'b00;
  localparam logic [1:0] RESP_OK    = 2'b01;
  localparam logic [1:0] RESP_ERROR = 2'b10;
  localparam logic [1:0] RESP_OTHER = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_LINE,
    ST_CLASSIFY,
    ST_REPORT
  } state_t;

  // Maps a finished line (length, overflow flag, first five bytes) to a response code.
  function automatic logic [1:0] classify_line(input logic [4:0]      len,
                                               input logic            ovf,
                                               input logic [4:0][7:0] head);
    logic [1:0] code;
    code = RESP_OTHER;
    if (!ovf && len == 5'd2 && head[0] == 8'h4F && head[1] == 8'h4B)
      code = RESP_OK;
    else if (!ovf && len == 5'd5 && head[0] == 8'h45 && head[1] == 8'h52 &&
             head[2] == 8'h52 && head[3] == 8'h4F && head[4] == 8'h52)
      code = RESP_ERROR;
    return code;
  endfunction

endpackage

// File: rtl/zigbee_line_buffer.sv
// Line storage with write pointer: MAX_LINE x 8, synchronous write, asynchronous read.
module zigbee_line_buffer #(
  parameter int MAX_LINE = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_Clear,
  input  logic            i_Wr_En,
  input  logic [7:0]      i_Byte,
  input  logic [3:0]      i_Rd_Addr,
  output logic [7:0]      o_Rd_Data,
  output logic [4:0]      o_Len,
  output logic            o_Full,
  output logic [4:0][7:0] o_Head
);

  localparam int AW = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;

  logic [7:0] r_Mem [MAX_LINE];
  logic [4:0] r_Len;
  logic       w_Full;

  assign w_Full    = (r_Len == 5'(MAX_LINE));
  assign o_Full    = w_Full;
  assign o_Len     = r_Len;
  assign o_Rd_Data = r_Mem[i_Rd_Addr];
  assign o_Head    = {r_Mem[4], r_Mem[3], r_Mem[2], r_Mem[1], r_Mem[0]};

  // Write pointer: cleared on arm, advances per stored byte until the buffer is full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_Len <= '0;
    else if (i_Clear)
      r_Len <= '0;
    else if (i_Wr_En && !w_Full)
      r_Len <= r_Len + 5'd1;
  end

  // Byte storage: no reset needed, stale entries beyond the length are don't-care.
  always_ff @(posedge clk) begin
    if (i_Wr_En && !w_Full)
      r_Mem[r_Len[AW-1:0]] <= i_Byte;
  end

endmodule

// File: rtl/zigbee_at_response_parser.sv
// Awaits one AT response line after an arm request, classifies it, or times out.
module zigbee_at_response_parser
  import zigbee_pkg::*;
#(
  parameter int CLOCK_FREQ     = 100_000_000,
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int MAX_LINE       = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_Data_Valid,
  input  logic [7:0] i_Byte,
  input  logic       i_Arm,
  output logic       o_Busy,
  output logic       o_Resp_Valid,
  output logic [1:0] o_Resp_Code,
  output logic       o_Timeout,
  output logic [4:0] o_Line_Len,
  output logic       o_Overflow,
  input  logic [3:0] i_Rd_Addr,
  output logic [7:0] o_Rd_Data
);

  localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  if (CLOCK_FREQ < 1) begin : g_bad_clock
    $error("CLOCK_FREQ must be positive");
  end

  state_t          r_State, w_Next_State;
  logic [TW-1:0]   r_Tmo_Cnt;
  logic            r_Timeout;
  logic            r_Overflow;
  logic [1:0]      r_Resp_Code;
  logic            w_Arm, w_Store, w_Tmo_Hit;
  logic [4:0]      w_Len;
  logic            w_Full;
  logic [4:0][7:0] w_Head;

  zigbee_line_buffer #(.MAX_LINE(MAX_LINE)) u_line_buffer (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_Clear   (w_Arm),
    .i_Wr_En   (w_Store),
    .i_Byte    (i_Byte),
    .i_Rd_Addr (i_Rd_Addr),
    .o_Rd_Data (o_Rd_Data),
    .o_Len     (w_Len),
    .o_Full    (w_Full),
    .o_Head    (w_Head)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_State <= ST_IDLE;
    else
      r_State <= w_Next_State;
  end

  // Next state and control strobes; an accepted CR takes priority over the timeout terminal count.
  always_comb begin
    w_Next_State = r_State;
    w_Arm        = 1'b0;
    w_Store      = 1'b0;
    w_Tmo_Hit    = 1'b0;
    o_Busy       = 1'b0;
    o_Resp_Valid = 1'b0;
    case (r_State)
      ST_IDLE: begin
        if (i_Arm) begin
          w_Arm        = 1'b1;
          w_Next_State = ST_WAIT_LINE;
        end
      end
      ST_WAIT_LINE: begin
        o_Busy = 1'b1;
        if (i_Data_Valid && i_Byte == CHAR_CR && w_Len != 5'd0) begin
          w_Next_State = ST_CLASSIFY;
        end else begin
          if (i_Data_Valid && i_Byte != CHAR_CR && i_Byte != CHAR_LF)
            w_Store = 1'b1;
          if (r_Tmo_Cnt == TMO_LAST) begin
            w_Tmo_Hit    = 1'b1;
            w_Next_State = ST_IDLE;
          end
        end
      end
      ST_CLASSIFY: begin
        o_Busy       = 1'b1;
        w_Next_State = ST_REPORT;
      end
      ST_REPORT: begin
        o_Busy       = 1'b1;
        o_Resp_Valid = 1'b1;
        w_Next_State = ST_IDLE;
      end
      default: w_Next_State = ST_IDLE;
    endcase
  end

  // Timeout counter, timeout strobe, overflow flag and response code.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_Tmo_Cnt   <= '0;
      r_Timeout   <= 1'b0;
      r_Overflow  <= 1'b0;
      r_Resp_Code <= RESP_NONE;
    end else begin
      r_Timeout <= w_Tmo_Hit;
      if (w_Arm) begin
        r_Tmo_Cnt   <= '0;
        r_Overflow  <= 1'b0;
        r_Resp_Code <= RESP_NONE;
      end else begin
        if (r_State == ST_WAIT_LINE)
          r_Tmo_Cnt <= r_Tmo_Cnt + 1'b1;
        if (w_Store && w_Full)
          r_Overflow <= 1'b1;
        if (r_State == ST_CLASSIFY)
          r_Resp_Code <= classify_line(w_Len, r_Overflow, w_Head);
      end
    end
  end

  assign o_Timeout   = r_Timeout;
  assign o_Overflow  = r_Overflow;
  assign o_Resp_Code = r_Resp_Code;
  assign o_Line_Len  = w_Len;

endmodule

// File: tb/tb_zigbee_at_response_parser.sv
// Directed self-checking bench for zigbee_at_response_parser.
module tb_zigbee_at_response_parser;

  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       i_Data_Valid = 1'b0;
  logic [7:0] i_Byte = '0;
  logic       i_Arm = 1'b0;
  logic [3:0] i_Rd_Addr = '0;
  logic       o_Busy, o_Resp_Valid, o_Timeout, o_Overflow;
  logic [1:0] o_Resp_Code;
  logic [4:0] o_Line_Len;
  logic [7:0] o_Rd_Data;

  int n_vec = 0;
  int n_err = 0;

  zigbee_at_response_parser #(
    .CLOCK_FREQ     (100_000_000),
    .TIMEOUT_CYCLES (TMO),
    .MAX_LINE       (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_Data_Valid (i_Data_Valid),
    .i_Byte       (i_Byte),
    .i_Arm        (i_Arm),
    .o_Busy       (o_Busy),
    .o_Resp_Valid (o_Resp_Valid),
    .o_Resp_Code  (o_Resp_Code),
    .o_Timeout    (o_Timeout),
    .o_Line_Len   (o_Line_Len),
    .o_Overflow   (o_Overflow),
    .i_Rd_Addr    (i_Rd_Addr),
    .o_Rd_Data    (o_Rd_Data)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    i_Data_Valid = 1'b1;
    i_Byte       = b;
    tick();
    i_Data_Valid = 1'b0;
  endtask

  task automatic arm();
    i_Arm = 1'b1;
    tick();
    i_Arm = 1'b0;
  endtask

  // Runs up to budget cycles; any byte preloaded by the caller is applied for the first cycle only.
  task automatic watch(input int budget, output int first, output int n_tmo, output int n_resp,
                       output logic busy_at_tmo, output logic [1:0] code_at_tmo);
    first = 0; n_tmo = 0; n_resp = 0; busy_at_tmo = 1'b1; code_at_tmo = 2'b11;
    for (int k = 1; k <= budget; k++) begin
      tick();
      i_Data_Valid = 1'b0;
      if (o_Resp_Valid) n_resp++;
      if (o_Timeout) begin
        n_tmo++;
        if (first == 0) begin
          first = k;
          busy_at_tmo = o_Busy;
          code_at_tmo = o_Resp_Code;
        end
      end
    end
  endtask

  int         first, n_tmo, n_resp;
  logic       b_tmo;
  logic [1:0] c_tmo;

  initial begin
    // Reset state
    #3;
    chk("rst_busy", 32'(o_Busy), 0);
    chk("rst_valid", 32'(o_Resp_Valid), 0);
    chk("rst_code", 32'(o_Resp_Code), 0);
    chk("rst_len", 32'(o_Line_Len), 0);
    chk("rst_ovf", 32'(o_Overflow), 0);
    chk("rst_tmo", 32'(o_Timeout), 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // "OK" with a stray arm in the middle that must be ignored
    arm();
    chk("ok_busy", 32'(o_Busy), 1);
    send(8'h4F);
    arm();
    send(8'h4B);
    send(8'h0D);
    chk("ok_n1_valid", 32'(o_Resp_Valid), 0);
    chk("ok_n1_busy", 32'(o_Busy), 1);
    tick();
    chk("ok_valid", 32'(o_Resp_Valid), 1);
    chk("ok_code", 32'(o_Resp_Code), 1);
    chk("ok_len", 32'(o_Line_Len), 2);
    chk("ok_ovf", 32'(o_Overflow), 0);
    i_Rd_Addr = 4'd0; #1;
    chk("ok_rd0", 32'(o_Rd_Data), 32'h4F);
    i_Rd_Addr = 4'd1; #1;
    chk("ok_rd1", 32'(o_Rd_Data), 32'h4B);
    tick();
    chk("ok_after_valid", 32'(o_Resp_Valid), 0);
    chk("ok_after_busy", 32'(o_Busy), 0);
    chk("ok_after_code", 32'(o_Resp_Code), 1);

    // Blank line, LF, then "ERROR"
    arm();
    chk("err_arm_code", 32'(o_Resp_Code), 0);
    send(8'h0D);
    chk("err_blank_busy", 32'(o_Busy), 1);
    chk("err_blank_len", 32'(o_Line_Len), 0);
    send(8'h0A);
    chk("err_lf_len", 32'(o_Line_Len), 0);
    send(8'h45); send(8'h52); send(8'h52); send(8'h4F); send(8'h52);
    send(8'h0D);
    tick();
    chk("err_valid", 32'(o_Resp_Valid), 1);
    chk("err_code", 32'(o_Resp_Code), 2);
    chk("err_len", 32'(o_Line_Len), 5);
    i_Rd_Addr = 4'd4; #1;
    chk("err_rd4", 32'(o_Rd_Data), 32'h52);
    tick();

    // Overflow: 20 x "A"
    arm();
    for (int i = 0; i < 20; i++) send(8'h41);
    chk("ovf_flag_pre", 32'(o_Overflow), 1);
    chk("ovf_len_pre", 32'(o_Line_Len), 16);
    send(8'h0D);
    tick();
    chk("ovf_valid", 32'(o_Resp_Valid), 1);
    chk("ovf_code", 32'(o_Resp_Code), 3);
    chk("ovf_len", 32'(o_Line_Len), 16);
    chk("ovf_flag", 32'(o_Overflow), 1);
    i_Rd_Addr = 4'd15; #1;
    chk("ovf_rd15", 32'(o_Rd_Data), 32'h41);
    tick();

    // Reset mid-line abandons the line
    arm();
    chk("rml_arm_ovf", 32'(o_Overflow), 0);
    send(8'h4F); send(8'h4B);
    chk("rml_len_pre", 32'(o_Line_Len), 2);
    reset_n = 1'b0;
    #1;
    chk("rml_busy", 32'(o_Busy), 0);
    chk("rml_len", 32'(o_Line_Len), 0);
    chk("rml_code", 32'(o_Resp_Code), 0);
    chk("rml_valid", 32'(o_Resp_Valid), 0);
    tick();
    reset_n = 1'b1;
    watch(5, first, n_tmo, n_resp, b_tmo, c_tmo);
    chk("rml_no_resp", 32'(n_resp), 0);
    chk("rml_no_tmo", 32'(n_tmo), 0);
    arm();
    send(8'h4F); send(8'h4B); send(8'h0D);
    tick();
    chk("rml_ok_valid", 32'(o_Resp_Valid), 1);
    chk("rml_ok_code", 32'(o_Resp_Code), 1);
    tick();

    // Timeout with no bytes
    arm();
    watch(130, first, n_tmo, n_resp, b_tmo, c_tmo);
    chk("tmo_cycle", 32'(first), 100);
    chk("tmo_pulses", 32'(n_tmo), 1);
    chk("tmo_busy", 32'(b_tmo), 0);
    chk("tmo_code", 32'(c_tmo), 0);
    chk("tmo_no_resp", 32'(n_resp), 0);

    // CR on the terminal-count cycle wins over timeout
    arm();
    send(8'h4F);
    for (int i = 0; i < 98; i++) tick();
    send(8'h0D);
    chk("race_tmo_n1", 32'(o_Timeout), 0);
    chk("race_busy_n1", 32'(o_Busy), 1);
    tick();
    chk("race_valid", 32'(o_Resp_Valid), 1);
    chk("race_code", 32'(o_Resp_Code), 3);
    chk("race_tmo_n2", 32'(o_Timeout), 0);
    tick();

    // Bytes while idle are discarded; blank CR after arm -> timeout only
    send(8'h4F); send(8'h4B); send(8'h0D);
    chk("idle_len", 32'(o_Line_Len), 1);
    chk("idle_busy", 32'(o_Busy), 0);
    tick(); tick();
    chk("idle_no_valid", 32'(o_Resp_Valid), 0);
    arm();
    i_Data_Valid = 1'b1;
    i_Byte       = 8'h0D;
    watch(130, first, n_tmo, n_resp, b_tmo, c_tmo);
    chk("idle_tmo_cycle", 32'(first), 100);
    chk("idle_tmo_pulses", 32'(n_tmo), 1);
    chk("idle_no_resp", 32'(n_resp), 0);
    chk("idle_tmo_code", 32'(c_tmo), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
